// File: rtl/muldiv_sequencer_pkg.sv
// Shared pipeline types and helpers for the RV64M multiply/divide sequencer.
// Decode/hazard logic reuses is_md() to know which instructions may stall.
package muldiv_sequencer_pkg;

    localparam int XLEN     = 64;
    localparam int MD_ITERS = 64;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_AND   = 5'd2,
        ALU_OR    = 5'd3,
        ALU_XOR   = 5'd4,
        ALU_SLL   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_SLT   = 5'd8,
        ALU_SLTU  = 5'd9,
        ALU_MUL   = 5'd16,
        ALU_DIV   = 5'd17,
        ALU_REM   = 5'd18,
        ALU_DIVU  = 5'd19,
        ALU_REMU  = 5'd20,
        ALU_MULW  = 5'd21,
        ALU_DIVW  = 5'd22,
        ALU_REMW  = 5'd23,
        ALU_DIVUW = 5'd24,
        ALU_REMUW = 5'd25
    } alufunc_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam word_t MIN64     = 64'h8000_0000_0000_0000;
    localparam word_t MIN32_EXT = 64'hFFFF_FFFF_8000_0000;
    localparam word_t ALL_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic is_md(input alufunc_t f);
        case (f)
            ALU_MUL, ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU,
            ALU_MULW, ALU_DIVW, ALU_REMW, ALU_DIVUW, ALU_REMUW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_mul_op(input alufunc_t f);
        case (f)
            ALU_MUL, ALU_MULW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_rem_op(input alufunc_t f);
        case (f)
            ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_w_op(input alufunc_t f);
        case (f)
            ALU_MULW, ALU_DIVW, ALU_REMW, ALU_DIVUW, ALU_REMUW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_div(input alufunc_t f);
        case (f)
            ALU_DIV, ALU_REM, ALU_DIVW, ALU_REMW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_unsigned_w(input alufunc_t f);
        case (f)
            ALU_DIVUW, ALU_REMUW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // W ops work on [31:0]; unsigned W divides zero-extend, all other W ops sign-extend.
    function automatic word_t prep_operand(input alufunc_t f, input word_t v);
        word_t r;
        if (is_unsigned_w(f)) begin
            r = {32'd0, v[31:0]};
        end else if (is_w_op(f)) begin
            r = {{32{v[31]}}, v[31:0]};
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic word_t w_ext(input logic w, input word_t v);
        word_t r;
        if (w) begin
            r = {{32{v[31]}}, v[31:0]};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand registers, shift-add / restoring-divide iteration, sign fix-up and W extension.
// The final result is registered on the same edge as the last iteration.
module muldiv_datapath
    import muldiv_sequencer_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     start,
    input  logic     step,
    input  logic     last,
    input  logic     load_special,
    input  alufunc_t func,
    input  word_t    opa,
    input  word_t    opb,
    input  word_t    special_value,
    output word_t    result
);

    // opa_r: multiplier (shifts right) or dividend/quotient (shifts left)
    // opb_r: multiplicand (shifts left) or divisor; acc_r: product or partial remainder
    word_t      opa_r;
    word_t      opb_r;
    word_t      acc_r;
    logic       is_mul_r;
    logic       is_rem_r;
    logic       is_w_r;
    logic       neg_q_r;
    logic       neg_r_r;
    word_t      result_r;

    logic       sgn_s;
    word_t      abs_a_s;
    word_t      abs_b_s;
    logic [64:0] rem_sh_s;
    logic [64:0] diff_s;
    word_t      nxt_opa_s;
    word_t      nxt_opb_s;
    word_t      nxt_acc_s;
    word_t      quo_s;
    word_t      rem_s;
    word_t      raw_s;
    word_t      final_s;

    // Absolute values for signed divides; multiplies and unsigned ops pass through
    always_comb begin
        sgn_s = is_signed_div(func);
        if (sgn_s && opa[63]) begin
            abs_a_s = ~opa + 64'd1;
        end else begin
            abs_a_s = opa;
        end
        if (sgn_s && opb[63]) begin
            abs_b_s = ~opb + 64'd1;
        end else begin
            abs_b_s = opb;
        end
    end

    // One iteration: conditional add for multiply, subtract-compare for divide
    always_comb begin
        nxt_opa_s = opa_r;
        nxt_opb_s = opb_r;
        nxt_acc_s = acc_r;
        rem_sh_s  = {acc_r, opa_r[63]};
        diff_s    = rem_sh_s - {1'b0, opb_r};
        if (is_mul_r) begin
            nxt_acc_s = acc_r + (opa_r[0] ? opb_r : 64'd0);
            nxt_opa_s = {1'b0, opa_r[63:1]};
            nxt_opb_s = {opb_r[62:0], 1'b0};
        end else if (rem_sh_s >= {1'b0, opb_r}) begin
            nxt_acc_s = diff_s[63:0];
            nxt_opa_s = {opa_r[62:0], 1'b1};
        end else begin
            nxt_acc_s = rem_sh_s[63:0];
            nxt_opa_s = {opa_r[62:0], 1'b0};
        end
    end

    // Sign fix-up and W extension of the post-iteration values
    always_comb begin
        if (neg_q_r) begin
            quo_s = ~nxt_opa_s + 64'd1;
        end else begin
            quo_s = nxt_opa_s;
        end
        if (neg_r_r) begin
            rem_s = ~nxt_acc_s + 64'd1;
        end else begin
            rem_s = nxt_acc_s;
        end
        if (is_mul_r) begin
            raw_s = nxt_acc_s;
        end else if (is_rem_r) begin
            raw_s = rem_s;
        end else begin
            raw_s = quo_s;
        end
        final_s = w_ext(is_w_r, raw_s);
    end

    // Operand latch, iteration state and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            opa_r    <= 64'd0;
            opb_r    <= 64'd0;
            acc_r    <= 64'd0;
            is_mul_r <= 1'b0;
            is_rem_r <= 1'b0;
            is_w_r   <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            result_r <= 64'd0;
        end else begin
            if (start) begin
                opa_r    <= abs_a_s;
                opb_r    <= abs_b_s;
                acc_r    <= 64'd0;
                is_mul_r <= is_mul_op(func);
                is_rem_r <= is_rem_op(func);
                is_w_r   <= is_w_op(func);
                neg_q_r  <= sgn_s & (opa[63] ^ opb[63]);
                neg_r_r  <= sgn_s & opa[63];
            end else if (step) begin
                opa_r <= nxt_opa_s;
                opb_r <= nxt_opb_s;
                acc_r <= nxt_acc_s;
            end
            if (load_special) begin
                result_r <= special_value;
            end else if (step && last) begin
                result_r <= final_s;
            end
        end
    end

    assign result = result_r;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV64M sequencer: FSM, iteration counter, special-case detection, stall/done.
// Divide-by-zero and signed overflow bypass the iterations and finish one cycle after accept.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int ITERS = MD_ITERS
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     valid_i,
    input  alufunc_t func,
    input  word_t    a,
    input  word_t    b,
    input  logic     flush,
    output logic     stall,
    output logic     done,
    output word_t    result
);

    localparam int CNT_W = $clog2(ITERS);

    md_state_t        state_r;
    md_state_t        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             done_r;

    logic  req_s;
    logic  div_zero_s;
    logic  ovf_s;
    logic  special_s;
    logic  start_s;
    logic  load_special_s;
    logic  step_s;
    logic  last_s;
    word_t opa_s;
    word_t opb_s;
    word_t special_raw_s;
    word_t special_value_s;

    // Operand preparation and special-case detection on the request
    always_comb begin
        req_s      = valid_i & is_md(func);
        opa_s      = prep_operand(func, a);
        opb_s      = prep_operand(func, b);
        div_zero_s = req_s & ~is_mul_op(func) & (opb_s == 64'd0);
        if (is_w_op(func)) begin
            ovf_s = is_signed_div(func) & (opa_s == MIN32_EXT) & (opb_s == ALL_ONES);
        end else begin
            ovf_s = is_signed_div(func) & (opa_s == MIN64) & (opb_s == ALL_ONES);
        end
        special_s = div_zero_s | ovf_s;
        if (is_rem_op(func)) begin
            special_raw_s = ovf_s ? 64'd0 : opa_s;
        end else begin
            special_raw_s = div_zero_s ? ALL_ONES : opa_s;
        end
        special_value_s = w_ext(is_w_op(func), special_raw_s);
    end

    // State, counter and done registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= MD_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_nxt_s == MD_DONE);
            if (start_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (step_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state: flush overrides everything, DONE never re-accepts
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = MD_IDLE;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (req_s) begin
                        state_nxt_s = special_s ? MD_DONE : MD_BUSY;
                    end else begin
                        state_nxt_s = MD_IDLE;
                    end
                end
                MD_BUSY: begin
                    if (last_s) begin
                        state_nxt_s = MD_DONE;
                    end else begin
                        state_nxt_s = MD_BUSY;
                    end
                end
                MD_DONE: state_nxt_s = MD_IDLE;
                default: state_nxt_s = MD_IDLE;
            endcase
        end
    end

    // Datapath controls decoded from the current state
    always_comb begin
        start_s        = 1'b0;
        load_special_s = 1'b0;
        step_s         = 1'b0;
        last_s         = 1'b0;
        case (state_r)
            MD_IDLE: begin
                start_s        = req_s & ~flush & ~special_s;
                load_special_s = req_s & ~flush & special_s;
            end
            MD_BUSY: begin
                step_s = ~flush;
                last_s = (cnt_r == CNT_W'(ITERS - 1));
            end
            MD_DONE: begin
                step_s = 1'b0;
            end
            default: begin
                step_s = 1'b0;
            end
        endcase
    end

    muldiv_datapath u_datapath (
        .clk           (clk),
        .reset         (reset),
        .start         (start_s),
        .step          (step_s),
        .last          (last_s),
        .load_special  (load_special_s),
        .func          (func),
        .opa           (opa_s),
        .opb           (opb_s),
        .special_value (special_value_s),
        .result        (result)
    );

    assign stall = valid_i & is_md(func) & ~done_r;
    assign done  = done_r;

endmodule
